// File: rtl/msg_build_arbiter.sv
// Round-robin arbiter sharing one SHA-2 message builder between NUM_REQ requesters.
// Defining MSG_ARB_TAG_EN adds a tag FIFO that reports which requester owns the message leaving the builder.
//
// state | meaning
// IDLE  | no owner; picks the next requester round-robin from last_grant
// CFG   | owner's config beat passes through to the builder
// DATA  | owner's data words pass through until the data_in_last handshake
module msg_build_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    sync_rst,
  input  logic                    en,
  input  logic [NUM_REQ*64-1:0]   req_cfg_size,
  input  logic [NUM_REQ*2-1:0]    req_cfg_scheme,
  input  logic [NUM_REQ-1:0]      req_cfg_last,
  input  logic [NUM_REQ-1:0]      req_cfg_valid,
  output logic [NUM_REQ-1:0]      req_cfg_ready,
  input  logic [NUM_REQ*512-1:0]  req_data_in,
  input  logic [NUM_REQ-1:0]      req_data_in_last,
  input  logic [NUM_REQ-1:0]      req_data_in_valid,
  output logic [NUM_REQ-1:0]      req_data_in_ready,
  output logic [63:0]             cfg_size,
  output logic [1:0]              cfg_scheme,
  output logic                    cfg_last,
  output logic                    cfg_valid,
  input  logic                    cfg_ready,
  output logic [511:0]            data_in,
  output logic                    data_in_last,
  output logic                    data_in_valid,
  input  logic                    data_in_ready,
  input  logic                    bld_out_valid,
  input  logic                    bld_out_ready,
  input  logic                    bld_out_last,
  output logic [ID_W-1:0]         grant_id,
  output logic                    grant_active,
  output logic [ID_W-1:0]         out_id
);

  typedef enum logic [1:0] {IDLE, CFG, DATA} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic            tag_full;
  logic            cfg_hs, data_hs;

  logic [63:0]        sel_size;
  logic [1:0]         sel_scheme;
  logic               sel_clast, sel_cvalid;
  logic [511:0]       sel_data;
  logic               sel_dlast, sel_dvalid;
  logic [NUM_REQ-1:0] grant_oh;

  // First requester with cfg_valid, searching upward from last+1 with wrap-around.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0] last);
    logic [ID_W-1:0]    p;
    logic [NUM_REQ-1:0] vs;
    int                 idx;
    p = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      vs  = v >> idx;
      if (vs[0]) p = ID_W'(idx);
    end
    return p;
  endfunction

  always_comb begin
    sel_size   = '0;
    sel_scheme = '0;
    sel_clast  = 1'b0;
    sel_cvalid = 1'b0;
    sel_data   = '0;
    sel_dlast  = 1'b0;
    sel_dvalid = 1'b0;
    grant_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        grant_oh[i] = 1'b1;
        sel_size    = req_cfg_size[i*64 +: 64];
        sel_scheme  = req_cfg_scheme[i*2 +: 2];
        sel_clast   = req_cfg_last[i];
        sel_cvalid  = req_cfg_valid[i];
        sel_data    = req_data_in[i*512 +: 512];
        sel_dlast   = req_data_in_last[i];
        sel_dvalid  = req_data_in_valid[i];
      end
    end
  end

  assign cfg_hs  = en && (state_q == CFG)  && sel_cvalid && cfg_ready;
  assign data_hs = en && (state_q == DATA) && sel_dvalid && data_in_ready;

  always_comb begin
    state_d           = state_q;
    grant_id_d        = grant_id_q;
    last_grant_d      = last_grant_q;
    cfg_size          = '0;
    cfg_scheme        = '0;
    cfg_last          = 1'b0;
    cfg_valid         = 1'b0;
    data_in           = '0;
    data_in_last      = 1'b0;
    data_in_valid     = 1'b0;
    req_cfg_ready     = '0;
    req_data_in_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (en && (|req_cfg_valid) && !tag_full) begin
          grant_id_d = rr_pick(req_cfg_valid, last_grant_q);
          state_d    = CFG;
        end
      end
      CFG: begin
        if (en) begin
          cfg_size      = sel_size;
          cfg_scheme    = sel_scheme;
          cfg_last      = sel_clast;
          cfg_valid     = sel_cvalid;
          req_cfg_ready = grant_oh & {NUM_REQ{cfg_ready}};
        end
        if (cfg_hs) state_d = DATA;
      end
      DATA: begin
        if (en) begin
          data_in           = sel_data;
          data_in_last      = sel_dlast;
          data_in_valid     = sel_dvalid;
          req_data_in_ready = grant_oh & {NUM_REQ{data_in_ready}};
        end
        if (data_hs && sel_dlast) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign grant_id     = grant_id_q;
  assign grant_active = (state_q != IDLE);

`ifdef MSG_ARB_TAG_EN
  localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  logic [ID_W-1:0]   tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [TAG_AW:0]   tag_cnt_q;
  logic              tag_push, tag_pop;

  assign tag_push = cfg_hs;
  assign tag_pop  = en && bld_out_valid && bld_out_ready && bld_out_last && (tag_cnt_q != '0);
  assign tag_full = (tag_cnt_q == (TAG_AW+1)'(TAG_DEPTH));
  assign out_id   = (tag_cnt_q != '0) ? tag_mem[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (tag_push) wr_ptr_q <= wr_ptr_q + TAG_AW'(1);
      if (tag_pop)  rd_ptr_q <= rd_ptr_q + TAG_AW'(1);
      if (tag_push && !tag_pop)      tag_cnt_q <= tag_cnt_q + (TAG_AW+1)'(1);
      else if (!tag_push && tag_pop) tag_cnt_q <= tag_cnt_q - (TAG_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[wr_ptr_q] <= grant_id_q;
  end
`else
  logic unused_bld;
  assign unused_bld = ^{bld_out_valid, bld_out_ready, bld_out_last};
  assign tag_full   = 1'b0;
  assign out_id     = '0;
`endif

endmodule

// File: tb/tb_msg_build_arbiter.sv
// Randomized scoreboard bench for msg_build_arbiter: messages are queued per requester and
// the monitor checks grant order, pass-through and message content against a transaction model.
module tb_msg_build_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int ID_W      = 2;
  localparam int TAG_DEPTH = 4;
  localparam int MSGS      = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   sync_rst, en;
  logic [NUM_REQ*64-1:0]  req_cfg_size;
  logic [NUM_REQ*2-1:0]   req_cfg_scheme;
  logic [NUM_REQ-1:0]     req_cfg_last, req_cfg_valid, req_cfg_ready;
  logic [NUM_REQ*512-1:0] req_data_in;
  logic [NUM_REQ-1:0]     req_data_in_last, req_data_in_valid, req_data_in_ready;
  logic [63:0]            cfg_size;
  logic [1:0]             cfg_scheme;
  logic                   cfg_last, cfg_valid, cfg_ready;
  logic [511:0]           data_in;
  logic                   data_in_last, data_in_valid, data_in_ready;
  logic                   bld_out_valid, bld_out_ready, bld_out_last;
  logic [ID_W-1:0]        grant_id, out_id;
  logic                   grant_active;

  msg_build_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .sync_rst(sync_rst), .en(en),
    .req_cfg_size(req_cfg_size), .req_cfg_scheme(req_cfg_scheme), .req_cfg_last(req_cfg_last),
    .req_cfg_valid(req_cfg_valid), .req_cfg_ready(req_cfg_ready),
    .req_data_in(req_data_in), .req_data_in_last(req_data_in_last),
    .req_data_in_valid(req_data_in_valid), .req_data_in_ready(req_data_in_ready),
    .cfg_size(cfg_size), .cfg_scheme(cfg_scheme), .cfg_last(cfg_last),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .data_in(data_in), .data_in_last(data_in_last), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .bld_out_valid(bld_out_valid), .bld_out_ready(bld_out_ready), .bld_out_last(bld_out_last),
    .grant_id(grant_id), .grant_active(grant_active), .out_id(out_id)
  );

  typedef struct { logic [63:0] size; logic [1:0] scheme; logic last; } cfg_t;
  typedef struct { logic [511:0] data; logic last; } word_t;

  cfg_t  drv_cfg_q[NUM_REQ][$];
  cfg_t  exp_cfg_q[NUM_REQ][$];
  word_t drv_dat_q[NUM_REQ][$];
  word_t exp_dat_q[NUM_REQ][$];
  int    tags[$];

  int n_checks = 0, n_pass = 0;
  int phase = 0, owner = 0, last_g = NUM_REQ - 1, msgs_done = 0;
  logic [NUM_REQ-1:0] hs_cfg = '0, hs_dat = '0, drop_req = '0, drop_cfg = '0;
  logic hold_dready = 1'b0;

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference round-robin: first valid requester after the previous owner.
  function automatic int rr_ref(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx = (last + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic push_msg(input int r, input int n, input logic [63:0] sz);
    cfg_t  c;
    word_t w;
    c.size = sz; c.scheme = 2'($urandom_range(0, 3)); c.last = 1'($urandom_range(0, 1));
    drv_cfg_q[r].push_back(c);
    exp_cfg_q[r].push_back(c);
    for (int k = 0; k < n; k++) begin
      w.data = rnd512(); w.last = (k == n - 1);
      drv_dat_q[r].push_back(w);
      exp_dat_q[r].push_back(w);
    end
  endtask

  function automatic logic all_idle();
    logic e = (phase == 0);
    for (int i = 0; i < NUM_REQ; i++)
      if (drv_cfg_q[i].size() != 0 || drv_dat_q[i].size() != 0 ||
          exp_cfg_q[i].size() != 0 || exp_dat_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Driver: retire accepted beats, then present the next ones with random gaps.
  cfg_t  dc;
  word_t dw;
  logic  dd;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (drop_req[i]) begin
        if (drop_cfg[i] && drv_cfg_q[i].size() > 0) dc = drv_cfg_q[i].pop_front();
        dd = 1'b0;
        while (!dd && drv_dat_q[i].size() > 0) begin
          dw = drv_dat_q[i].pop_front();
          dd = dw.last;
        end
      end else begin
        if (hs_cfg[i] && drv_cfg_q[i].size() > 0) dc = drv_cfg_q[i].pop_front();
        if (hs_dat[i] && drv_dat_q[i].size() > 0) dw = drv_dat_q[i].pop_front();
      end
      if (drv_cfg_q[i].size() > 0) begin
        dc = drv_cfg_q[i][0];
        req_cfg_valid[i] = ($urandom_range(0, 3) != 0);
      end else begin
        dc.size = {$urandom, $urandom}; dc.scheme = 2'($urandom); dc.last = 1'($urandom);
        req_cfg_valid[i] = 1'b0;
      end
      req_cfg_size[i*64 +: 64]  = dc.size;
      req_cfg_scheme[i*2 +: 2]  = dc.scheme;
      req_cfg_last[i]           = dc.last;
      if (drv_dat_q[i].size() > 0) begin
        dw = drv_dat_q[i][0];
        req_data_in_valid[i] = ($urandom_range(0, 3) != 0);
      end else begin
        dw.data = rnd512(); dw.last = 1'($urandom);
        req_data_in_valid[i] = 1'b0;
      end
      req_data_in[i*512 +: 512] = dw.data;
      req_data_in_last[i]       = dw.last;
    end
    cfg_ready     = ($urandom_range(0, 3) != 0);
    data_in_ready = hold_dready ? 1'b0 : ($urandom_range(0, 3) != 0);
    en            = ($urandom_range(0, 15) != 0);
    bld_out_valid = 1'($urandom);
    bld_out_ready = 1'($urandom);
    bld_out_last  = ($urandom_range(0, 3) == 0);
  end

  // Monitor: compare DUT against the transaction model, then advance the model across the coming edge.
  logic               e_cv, e_dv, e_clast, e_dlast, tag_room, pop_ok, push_tag;
  logic [NUM_REQ-1:0] e_crdy, e_drdy;
  logic [63:0]        e_size;
  logic [1:0]         e_sch;
  logic [511:0]       e_data;
  logic [ID_W-1:0]    e_oid;
  cfg_t               mc;
  word_t              mw;
  always @(negedge clk) begin
    e_cv = 0; e_dv = 0; e_clast = 0; e_dlast = 0; e_crdy = '0; e_drdy = '0;
    e_size = '0; e_sch = '0; e_data = '0;
    if (en && phase == 1) begin
      e_cv = req_cfg_valid[owner]; e_crdy[owner] = cfg_ready;
      e_size = req_cfg_size[owner*64 +: 64]; e_sch = req_cfg_scheme[owner*2 +: 2];
      e_clast = req_cfg_last[owner];
    end
    if (en && phase == 2) begin
      e_dv = req_data_in_valid[owner]; e_drdy[owner] = data_in_ready;
      e_data = req_data_in[owner*512 +: 512]; e_dlast = req_data_in_last[owner];
    end
`ifdef MSG_ARB_TAG_EN
    e_oid    = (tags.size() > 0) ? ID_W'(tags[0]) : '0;
    tag_room = (tags.size() < TAG_DEPTH);
`else
    e_oid    = '0;
    tag_room = 1'b1;
`endif
    chk("grant", {grant_active, (phase != 0) ? grant_id : 2'b00},
                 {(phase != 0), (phase != 0) ? ID_W'(owner) : 2'b00});
    chk("handshake_ctl", {cfg_valid, req_cfg_ready, data_in_valid, req_data_in_ready, out_id},
                         {e_cv, e_crdy, e_dv, e_drdy, e_oid});
    chk("cfg_bus", {cfg_size, cfg_scheme, cfg_last}, {e_size, e_sch, e_clast});
    chk("data_bus", {data_in_last, data_in}, {e_dlast, e_data});

    hs_cfg = '0; hs_dat = '0; drop_req = '0; drop_cfg = '0; push_tag = 1'b0;
    if (sync_rst) begin
      if (phase != 0) begin
        drop_req[owner] = 1'b1;
        if (phase == 1) begin
          drop_cfg[owner] = 1'b1;
          if (exp_cfg_q[owner].size() > 0) mc = exp_cfg_q[owner].pop_front();
        end
        mw.last = 1'b0;
        while (!mw.last && exp_dat_q[owner].size() > 0) mw = exp_dat_q[owner].pop_front();
      end
      phase = 0; last_g = NUM_REQ - 1; tags.delete();
    end else begin
      pop_ok = en && bld_out_valid && bld_out_ready && bld_out_last && (tags.size() > 0);
      if (phase == 1 && en && req_cfg_valid[owner] && cfg_ready) begin
        if (exp_cfg_q[owner].size() == 0) chk("cfg_expected", 0, 1);
        else begin
          mc = exp_cfg_q[owner].pop_front();
          chk("cfg_beat", {cfg_size, cfg_scheme, cfg_last}, {mc.size, mc.scheme, mc.last});
        end
        hs_cfg[owner] = 1'b1; phase = 2; push_tag = 1'b1;
      end else if (phase == 2 && en && req_data_in_valid[owner] && data_in_ready) begin
        if (exp_dat_q[owner].size() == 0) chk("data_expected", 0, 1);
        else begin
          mw = exp_dat_q[owner].pop_front();
          chk("data_beat", {data_in_last, data_in}, {mw.last, mw.data});
          if (mw.last) begin phase = 0; last_g = owner; msgs_done++; end
        end
        hs_dat[owner] = 1'b1;
      end else if (phase == 0 && en && (|req_cfg_valid) && tag_room) begin
        owner = rr_ref(req_cfg_valid, last_g); phase = 1;
      end
`ifdef MSG_ARB_TAG_EN
      if (pop_ok) void'(tags.pop_front());
      if (push_tag) tags.push_back(owner);
`endif
    end
  end

  task automatic wait_drain(input string nm);
    for (int c = 0; c < 5000; c++) begin
      if (all_idle()) break;
      @(posedge clk);
    end
    chk(nm, all_idle(), 1);
  endtask

  initial begin
    sync_rst = 1'b1; en = 1'b1;
    req_cfg_size = '0; req_cfg_scheme = '0; req_cfg_last = '0; req_cfg_valid = '0;
    req_data_in = '0; req_data_in_last = '0; req_data_in_valid = '0;
    cfg_ready = 1'b0; data_in_ready = 1'b0;
    bld_out_valid = 1'b0; bld_out_ready = 1'b0; bld_out_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {grant_active, grant_id, out_id, cfg_valid, data_in_valid, req_cfg_ready,
                        req_data_in_ready, cfg_size, cfg_scheme, cfg_last, data_in, data_in_last}, 0);
    @(posedge clk);
    #1 sync_rst = 1'b0;

    for (int m = 0; m < MSGS; m++) begin
      push_msg($urandom_range(0, NUM_REQ - 1), $urandom_range(1, 4), 64'($urandom_range(1, 2048)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain("random_drain");

    // Mid-message reset: drop requester 2 after its first of three words.
    push_msg(2, 3, 64'd24);
    begin
      int c;
      for (c = 0; c < 2000; c++) begin
        @(posedge clk);
        if (exp_dat_q[2].size() <= 2) break;
      end
      chk("first_word_wait", (c < 2000), 1);
    end
    hold_dready = 1'b1;
    #1 sync_rst = 1'b1;
    @(posedge clk);
    #1 sync_rst = 1'b0;
    hold_dready = 1'b0;
    @(negedge clk);
    chk("post_reset", {grant_active, req_cfg_ready, req_data_in_ready, out_id}, 0);
    push_msg(3, 1, 64'd8);
    push_msg(1, 2, 64'd700);
    wait_drain("post_reset_drain");
    chk("msgs_done", msgs_done, MSGS + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
